// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/decode/execute control unit driving every ALUSystem control input.
// Define CU_INSTR_COUNT_EN to add the InstrCount retired-instruction counter port.
module ctrl_sequencer #(
   parameter bit          CLEAR_ON_RESET = 1'b1,
   parameter int unsigned Z_BIT          = 3
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] IROut,
   input  logic [3:0]  ALUOutFlag,
   output logic [1:0]  ARF_OutASel,
   output logic [1:0]  ARF_OutBSel,
   output logic [1:0]  ARF_FunSel,
   output logic [3:0]  ARF_RSel,
   output logic [2:0]  RF_OutASel,
   output logic [2:0]  RF_OutBSel,
   output logic [1:0]  RF_FunSel,
   output logic [3:0]  RF_RSel,
   output logic [3:0]  RF_TSel,
   output logic [3:0]  ALU_FunSel,
   output logic        IR_Enable,
   output logic        IR_LH,
   output logic [1:0]  IR_Funsel,
   output logic        Mem_WR,
   output logic        Mem_CS,
   output logic [1:0]  MuxASel,
   output logic [1:0]  MuxBSel,
   output logic        MuxCSel,
   output logic        Halted
`ifdef CU_INSTR_COUNT_EN
   ,
   output logic [7:0]  InstrCount
`endif
);

   typedef enum logic [2:0] {
      StInit,
      StFetchL,
      StFetchH,
      StExec1,
      StExec2,
      StHalt
   } state_e;

   localparam logic [3:0] OpAnd = 4'h0;
   localparam logic [3:0] OpOr  = 4'h1;
   localparam logic [3:0] OpNot = 4'h2;
   localparam logic [3:0] OpAdd = 4'h3;
   localparam logic [3:0] OpSub = 4'h4;
   localparam logic [3:0] OpLsl = 4'h5;
   localparam logic [3:0] OpLsr = 4'h6;
   localparam logic [3:0] OpInc = 4'h7;
   localparam logic [3:0] OpDec = 4'h8;
   localparam logic [3:0] OpLdi = 4'h9;
   localparam logic [3:0] OpLd  = 4'hA;
   localparam logic [3:0] OpSt  = 4'hB;
   localparam logic [3:0] OpBra = 4'hC;
   localparam logic [3:0] OpBeq = 4'hD;
   localparam logic [3:0] OpBne = 4'hE;
   localparam logic [3:0] OpHlt = 4'hF;

   state_e     state_q, state_d;
   logic       z_q, z_d;
   logic [3:0] op;
   logic [1:0] rd, rs;
   logic       is_alu_op;
   logic       a_uses_rs;
   logic       branch_taken;
   logic [3:0] alu_fun;

   // The immediate reaches the datapath through MuxA/MuxB, never through this block.
   logic unused_inputs;
   assign unused_inputs = ^{IROut[7:0], ALUOutFlag};

   assign op = IROut[15:12];
   assign rd = IROut[11:10];
   assign rs = IROut[9:8];

   function automatic logic [3:0] reg_onehot(input logic [1:0] n);
      return 4'b1000 >> n;
   endfunction

   function automatic logic [2:0] reg_outsel(input logic [1:0] n);
      return {1'b1, n};
   endfunction

   always_comb begin
      is_alu_op = (op <= OpLsr);
      a_uses_rs = (op == OpNot) || (op == OpLsl) || (op == OpLsr);
      case (op)
         OpBra:   branch_taken = 1'b1;
         OpBeq:   branch_taken = z_q;
         OpBne:   branch_taken = !z_q;
         default: branch_taken = 1'b0;
      endcase
      case (op)
         OpAnd:   alu_fun = 4'b0111;
         OpOr:    alu_fun = 4'b1000;
         OpNot:   alu_fun = 4'b0010;
         OpAdd:   alu_fun = 4'b0100;
         OpSub:   alu_fun = 4'b0101;
         OpLsl:   alu_fun = 4'b1011;
         OpLsr:   alu_fun = 4'b1100;
         default: alu_fun = 4'b0000;
      endcase
   end

   always_comb begin
      state_d = state_q;
      z_d     = z_q;
      unique case (state_q)
         StInit:   state_d = StFetchL;
         StFetchL: state_d = StFetchH;
         StFetchH: state_d = StExec1;
         StExec1: begin
            if (is_alu_op) begin
               z_d     = ALUOutFlag[Z_BIT];
               state_d = StFetchL;
            end else if (op == OpLd || op == OpSt) begin
               state_d = StExec2;
            end else if (op == OpHlt) begin
               state_d = StHalt;
            end else begin
               state_d = StFetchL;
            end
         end
         StExec2:  state_d = StFetchL;
         StHalt:   state_d = StHalt;
         default:  state_d = StInit;
      endcase
   end

`ifdef CU_INSTR_COUNT_EN
   logic [7:0] instr_cnt_q, instr_cnt_d;

   always_comb begin
      instr_cnt_d = instr_cnt_q;
      if ((state_q == StExec1 || state_q == StExec2) && state_d == StFetchL) begin
         instr_cnt_d = instr_cnt_q + 8'd1;
      end
   end

   assign InstrCount = instr_cnt_q;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= StInit;
         z_q         <= 1'b0;
`ifdef CU_INSTR_COUNT_EN
         instr_cnt_q <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         z_q         <= z_d;
`ifdef CU_INSTR_COUNT_EN
         instr_cnt_q <= instr_cnt_d;
`endif
      end
   end

   // Reset forces idle controls so an aborted instruction writes nothing at that edge.
   always_comb begin
      ARF_OutASel = 2'b00;
      ARF_OutBSel = 2'b00;
      ARF_FunSel  = 2'b00;
      ARF_RSel    = 4'b0000;
      RF_OutASel  = 3'b000;
      RF_OutBSel  = 3'b000;
      RF_FunSel   = 2'b00;
      RF_RSel     = 4'b0000;
      RF_TSel     = 4'b0000;
      ALU_FunSel  = 4'b0000;
      IR_Enable   = 1'b0;
      IR_LH       = 1'b0;
      IR_Funsel   = 2'b00;
      Mem_WR      = 1'b0;
      Mem_CS      = 1'b1;
      MuxASel     = 2'b00;
      MuxBSel     = 2'b00;
      MuxCSel     = 1'b0;
      Halted      = (state_q == StHalt);
      if (!Reset) begin
         unique case (state_q)
            StInit: begin
               if (CLEAR_ON_RESET) begin
                  ARF_RSel  = 4'b1111;
                  RF_RSel   = 4'b1111;
                  RF_TSel   = 4'b1111;
                  IR_Enable = 1'b1;
               end
            end
            StFetchL, StFetchH: begin
               ARF_OutBSel = 2'b11;
               Mem_CS      = 1'b0;
               IR_Enable   = 1'b1;
               IR_Funsel   = 2'b01;
               IR_LH       = (state_q == StFetchH);
               ARF_RSel    = 4'b0001;
               ARF_FunSel  = 2'b11;
            end
            StExec1: begin
               unique case (op)
                  OpAnd, OpOr, OpNot, OpAdd, OpSub, OpLsl, OpLsr: begin
                     MuxCSel    = 1'b0;
                     RF_OutASel = a_uses_rs ? reg_outsel(rs) : reg_outsel(rd);
                     RF_OutBSel = reg_outsel(rs);
                     ALU_FunSel = alu_fun;
                     MuxASel    = 2'b00;
                     RF_RSel    = reg_onehot(rd);
                     RF_FunSel  = 2'b01;
                  end
                  OpInc, OpDec: begin
                     RF_RSel   = reg_onehot(rd);
                     RF_FunSel = (op == OpInc) ? 2'b11 : 2'b10;
                  end
                  OpLdi: begin
                     MuxASel   = 2'b10;
                     RF_RSel   = reg_onehot(rd);
                     RF_FunSel = 2'b01;
                  end
                  OpLd, OpSt: begin
                     MuxBSel    = 2'b10;
                     ARF_RSel   = 4'b1000;
                     ARF_FunSel = 2'b01;
                  end
                  OpBra, OpBeq, OpBne: begin
                     if (branch_taken) begin
                        MuxBSel    = 2'b10;
                        ARF_RSel   = 4'b0001;
                        ARF_FunSel = 2'b01;
                     end
                  end
                  OpHlt: ;
                  default: ;
               endcase
            end
            StExec2: begin
               ARF_OutBSel = 2'b00;
               Mem_CS      = 1'b0;
               if (op == OpSt) begin
                  MuxCSel    = 1'b0;
                  RF_OutASel = reg_outsel(rd);
                  ALU_FunSel = 4'b0000;
                  Mem_WR     = 1'b1;
               end else begin
                  MuxASel   = 2'b01;
                  RF_RSel   = reg_onehot(rd);
                  RF_FunSel = 2'b01;
               end
            end
            StHalt: ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench: ctrl_sequencer driving a small behavioural ALUSystem model (ARF, RF, IR, ALU, memory).
module tb_ctrl_sequencer;

   logic        Clock;
   logic        Reset;
   logic [15:0] IROut;
   logic [3:0]  ALUOutFlag;
   logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
   logic [3:0]  ARF_RSel;
   logic [2:0]  RF_OutASel, RF_OutBSel;
   logic [1:0]  RF_FunSel;
   logic [3:0]  RF_RSel, RF_TSel;
   logic [3:0]  ALU_FunSel;
   logic        IR_Enable, IR_LH;
   logic [1:0]  IR_Funsel;
   logic        Mem_WR, Mem_CS;
   logic [1:0]  MuxASel, MuxBSel;
   logic        MuxCSel;
   logic        Halted;
`ifdef CU_INSTR_COUNT_EN
   logic [7:0]  InstrCount;
`endif

   ctrl_sequencer dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .IROut      (IROut),
      .ALUOutFlag (ALUOutFlag),
      .ARF_OutASel(ARF_OutASel),
      .ARF_OutBSel(ARF_OutBSel),
      .ARF_FunSel (ARF_FunSel),
      .ARF_RSel   (ARF_RSel),
      .RF_OutASel (RF_OutASel),
      .RF_OutBSel (RF_OutBSel),
      .RF_FunSel  (RF_FunSel),
      .RF_RSel    (RF_RSel),
      .RF_TSel    (RF_TSel),
      .ALU_FunSel (ALU_FunSel),
      .IR_Enable  (IR_Enable),
      .IR_LH      (IR_LH),
      .IR_Funsel  (IR_Funsel),
      .Mem_WR     (Mem_WR),
      .Mem_CS     (Mem_CS),
      .MuxASel    (MuxASel),
      .MuxBSel    (MuxBSel),
      .MuxCSel    (MuxCSel),
      .Halted     (Halted)
`ifdef CU_INSTR_COUNT_EN
      ,
      .InstrCount (InstrCount)
`endif
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Datapath model state
   logic [7:0]  mem [256];
   logic [7:0]  pc, ar, sp, pcp;
   logic [7:0]  rr [4];
   logic [7:0]  tt [4];
   logic [15:0] ir;
   logic [7:0]  arf_a, arf_b, rf_a, rf_b, alu_a, alu_b, alu_out, mem_out, mux_a, mux_b;

   int n_total = 0;
   int n_bad   = 0;

   assign IROut = ir;

   always_comb begin
      case (ARF_OutASel)
         2'b00:   arf_a = ar;
         2'b01:   arf_a = sp;
         2'b10:   arf_a = pcp;
         default: arf_a = pc;
      endcase
      case (ARF_OutBSel)
         2'b00:   arf_b = ar;
         2'b01:   arf_b = sp;
         2'b10:   arf_b = pcp;
         default: arf_b = pc;
      endcase
      rf_a  = RF_OutASel[2] ? rr[RF_OutASel[1:0]] : tt[RF_OutASel[1:0]];
      rf_b  = RF_OutBSel[2] ? rr[RF_OutBSel[1:0]] : tt[RF_OutBSel[1:0]];
      alu_a = MuxCSel ? arf_a : rf_a;
      alu_b = rf_b;
      case (ALU_FunSel)
         4'b0000: alu_out = alu_a;
         4'b0010: alu_out = ~alu_a;
         4'b0100: alu_out = alu_a + alu_b;
         4'b0101: alu_out = alu_a - alu_b;
         4'b0111: alu_out = alu_a & alu_b;
         4'b1000: alu_out = alu_a | alu_b;
         4'b1011: alu_out = alu_a << 1;
         4'b1100: alu_out = alu_a >> 1;
         default: alu_out = 8'h00;
      endcase
      ALUOutFlag = {alu_out == 8'h00, 3'b000};
      mem_out    = mem[arf_b];
      case (MuxASel)
         2'b00:   mux_a = alu_out;
         2'b01:   mux_a = mem_out;
         2'b10:   mux_a = ir[7:0];
         default: mux_a = arf_a;
      endcase
      case (MuxBSel)
         2'b00:   mux_b = alu_out;
         2'b01:   mux_b = mem_out;
         2'b10:   mux_b = ir[7:0];
         default: mux_b = arf_a;
      endcase
   end

   function automatic logic [7:0] fun_apply(input logic [1:0] f, input logic [7:0] cur,
                                            input logic [7:0] val);
      case (f)
         2'b00:   return 8'h00;
         2'b01:   return val;
         2'b10:   return cur - 8'd1;
         default: return cur + 8'd1;
      endcase
   endfunction

   // Called right at the active edge, so it sees the pre-edge controls.
   task automatic model_edge();
      if (ARF_RSel[3]) ar  <= fun_apply(ARF_FunSel, ar, mux_b);
      if (ARF_RSel[2]) sp  <= fun_apply(ARF_FunSel, sp, mux_b);
      if (ARF_RSel[1]) pcp <= fun_apply(ARF_FunSel, pcp, mux_b);
      if (ARF_RSel[0]) pc  <= fun_apply(ARF_FunSel, pc, mux_b);
      for (int i = 0; i < 4; i++) begin
         if (RF_RSel[3-i]) rr[i] <= fun_apply(RF_FunSel, rr[i], mux_a);
         if (RF_TSel[3-i]) tt[i] <= fun_apply(RF_FunSel, tt[i], mux_a);
      end
      if (IR_Enable) begin
         if (IR_Funsel == 2'b00) ir <= 16'h0000;
         else if (IR_Funsel == 2'b01) begin
            if (IR_LH) ir[15:8] <= mem_out;
            else       ir[7:0]  <= mem_out;
         end
      end
      if (!Mem_CS && Mem_WR) mem[arf_b] <= alu_out;
   endtask

   task automatic tick();
      @(posedge Clock);
      model_edge();
      #1;
   endtask

   task automatic to_exec1();
      tick();
      tick();
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic put_instr(input logic [7:0] addr, input logic [15:0] instr);
      mem[addr]        <= instr[7:0];
      mem[addr + 8'd1] <= instr[15:8];
   endtask

   initial begin
      Reset = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      pc <= 8'h5A; ar <= 8'h5A; sp <= 8'h5A; pcp <= 8'h5A; ir <= 16'hBEEF;
      for (int i = 0; i < 4; i++) begin
         rr[i] <= 8'h5A;
         tt[i] <= 8'h5A;
      end
      #1;
      put_instr(8'h00, 16'h9005); // LDI R1,05
      put_instr(8'h02, 16'h9405); // LDI R2,05
      put_instr(8'h04, 16'h4100); // SUB R1,R2
      put_instr(8'h06, 16'hD020); // BEQ 20
      put_instr(8'h20, 16'hE040); // BNE 40
      put_instr(8'h22, 16'h9807); // LDI R3,07
      put_instr(8'h24, 16'h3900); // ADD R3,R2
      put_instr(8'h26, 16'hD060); // BEQ 60
      put_instr(8'h28, 16'hE030); // BNE 30
      put_instr(8'h30, 16'hA840); // LD R3,40
      put_instr(8'h32, 16'hB841); // ST R3,41
      put_instr(8'h34, 16'hF000); // HLT
      mem[8'h40] <= 8'hA5;

      tick();
      tick();
      Reset = 1'b0;
      #1;
      check_eq("init_arf_rsel", 32'(ARF_RSel), 'hF);
      check_eq("init_rf_rsel", 32'(RF_RSel), 'hF);
      check_eq("init_rf_tsel", 32'(RF_TSel), 'hF);
      check_eq("init_ir_en", 32'(IR_Enable), 1);
      check_eq("init_halted", 32'(Halted), 0);

      tick(); // FETCH_L
      check_eq("clr_pc", 32'(pc), 0);
      check_eq("clr_r1", 32'(rr[0]), 0);
      check_eq("clr_t4", 32'(tt[3]), 0);
      check_eq("clr_ir", 32'(ir), 0);
      check_eq("fl_cs", 32'(Mem_CS), 0);
      check_eq("fl_outb", 32'(ARF_OutBSel), 3);
      check_eq("fl_lh", 32'(IR_LH), 0);
      check_eq("fl_arf", 32'({ARF_RSel, ARF_FunSel}), 'b000111);
      tick(); // FETCH_H
      check_eq("fh_lh", 32'(IR_LH), 1);
      check_eq("fh_ir_lo", 32'(ir), 'h0005);
      tick(); // EXEC1 LDI R1
      check_eq("ldi_ir", 32'(ir), 'h9005);
      check_eq("ldi_pc", 32'(pc), 2);
      check_eq("ldi_ctl", 32'({MuxASel, RF_RSel, RF_FunSel}), 'b10_1000_01);
      tick();
      check_eq("ldi_r1", 32'(rr[0]), 5);

      to_exec1(); // LDI R2
      tick();
      to_exec1(); // SUB R1,R2
      check_eq("sub_fun", 32'(ALU_FunSel), 'b0101);
      check_eq("sub_rsel", 32'(RF_RSel), 'b1000);
      check_eq("sub_outsel", 32'({RF_OutASel, RF_OutBSel}), 'b100_101);
      tick();
      check_eq("sub_r1", 32'(rr[0]), 0);

      to_exec1(); // BEQ 20, Z=1
      check_eq("beq_t_rsel", 32'(ARF_RSel), 'b0001);
      tick();
      check_eq("beq_t_pc", 32'(pc), 'h20);
      to_exec1(); // BNE 40, Z=1
      check_eq("bne_n_rsel", 32'(ARF_RSel), 0);
      tick();
      check_eq("bne_n_pc", 32'(pc), 'h22);

      to_exec1(); // LDI R3
      tick();
      to_exec1(); // ADD R3,R2
      tick();
      check_eq("add_r3", 32'(rr[2]), 'h0C);
      to_exec1(); // BEQ 60, Z=0
      tick();
      check_eq("beq_n_pc", 32'(pc), 'h28);
      to_exec1(); // BNE 30, Z=0
      tick();
      check_eq("bne_t_pc", 32'(pc), 'h30);

      to_exec1(); // LD R3,40
      tick();     // EXEC2
      check_eq("ld_e2", 32'({Mem_CS, Mem_WR, MuxASel, RF_RSel}), 'b0_0_01_0010);
      tick();
      check_eq("ld_r3", 32'(rr[2]), 'hA5);
      check_eq("ld_back_fetch", 32'({Mem_CS, ARF_OutBSel, IR_LH}), 'b0_11_0);

      to_exec1(); // ST R3,41
      check_eq("st_e1_wr", 32'(Mem_WR), 0);
      tick();     // EXEC2
      check_eq("st_e2_wr", 32'({Mem_CS, Mem_WR}), 'b01);
      tick();
      check_eq("st_after_wr", 32'(Mem_WR), 0);
      check_eq("st_mem", 32'(mem[8'h41]), 'hA5);

      to_exec1(); // HLT
      check_eq("hlt_e1", 32'(Halted), 0);
      tick();
      for (int i = 0; i < 12; i++) begin
         check_eq("halt_flag", 32'(Halted), 1);
         check_eq("halt_idle", 32'({ARF_RSel, RF_RSel, RF_TSel, IR_Enable, Mem_WR, Mem_CS}), 1);
         tick();
      end

      // Abort during FETCH_H: IR high byte must not load.
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      tick(); // FETCH_L
      tick(); // FETCH_H
      Reset = 1'b1;
      #1;
      check_eq("rst_fh_iren", 32'(IR_Enable), 0);
      check_eq("rst_fh_arf", 32'(ARF_RSel), 0);
      tick();
      check_eq("rst_fh_ir", 32'(ir), 'h0005);
      check_eq("rst_fh_pc", 32'(pc), 1);
      check_eq("rst_halted", 32'(Halted), 0);
      Reset = 1'b0;
      #1;
      check_eq("rst_init", 32'(ARF_RSel), 'hF);

`ifdef CU_INSTR_COUNT_EN
      for (int i = 0; i < 256; i += 2) put_instr(8'(i), 16'h7C00); // INC R4
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      tick(); // FETCH_L
      check_eq("cnt_reset", 32'(InstrCount), 0);
      to_exec1();
      check_eq("inc_ctl", 32'({RF_RSel, RF_FunSel}), 'b0001_11);
      tick();
      check_eq("cnt_one", 32'(InstrCount), 1);
      check_eq("inc_r4", 32'(rr[3]), 1);
      for (int i = 1; i < 255; i++) begin
         to_exec1();
         tick();
      end
      check_eq("cnt_255", 32'(InstrCount), 'hFF);
      to_exec1();
      tick();
      check_eq("cnt_wrap", 32'(InstrCount), 0);
      check_eq("inc_r4_wrap", 32'(rr[3]), 0);
      check_eq("pc_wrap", 32'(pc), 0);
      put_instr(8'h00, 16'hE080); // BNE 80: taken only if Z stayed 0
      to_exec1();
      tick();
      check_eq("z_kept", 32'(pc), 'h80);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
